dmem_port_sched: RTL and testbench
==================================

# dmem_port_sched

Single-port data-memory scheduler between the store queue and the load unit of the out-of-order core. It drains committed stores from the store-queue head and issues speculative loads, one outstanding access at a time. It pulses the store-queue dequeue and the ROB store-commit acknowledgement when a write completes. It also squashes in-flight load responses on pipeline flush.

## Interface
- ROB_IDX_W, 5, ROB index width
- TAG_W, 4, load tag width, returned with load data
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- sq_valid  in  1  store-queue head entry present (store queue not empty)
- sq_addr  in  32  head store word-aligned address
- sq_wdata  in  32  head store data
- sq_wmask  in  4  head store byte mask; never 0 when sq_valid
- sq_rob_idx  in  ROB_IDX_W  ROB index of head store
- sq_deq  out  1  one-cycle pulse: pop store-queue head
- rob_head_valid  in  1  ROB head entry present
- rob_head_idx  in  ROB_IDX_W  ROB head index
- store_done  out  1  one-cycle pulse: head store written, ROB may retire it
- ld_req  in  1  load request pending (held until ld_gnt)
- ld_addr  in  32  load word-aligned address
- ld_rmask  in  4  load byte mask; never 0 when ld_req
- ld_tag  in  TAG_W  load tag
- ld_gnt  out  1  load accepted this cycle
- ld_resp  out  1  load data valid
- ld_rdata  out  32  load data
- ld_resp_tag  out  TAG_W  tag of returning load
- flush  in  1  pipeline squash; kills pending and in-flight loads only
- dmem_addr  out  32  memory address
- dmem_rmask  out  4  read mask; nonzero = read request
- dmem_wmask  out  4  write mask; nonzero = write request
- dmem_wdata  out  32  write data
- dmem_rdata  in  32  read data
- dmem_resp  in  1  access complete, one-cycle pulse

## Operation
- States: IDLE, STORE_WAIT, LOAD_WAIT. Reset: IDLE, drop flag 0, every output 0.
- Store eligibility: st_ok = sq_valid && rob_head_valid && sq_rob_idx == rob_head_idx.
- IDLE arbitration, in priority order:
  - st_ok: latch sq_addr/sq_wdata/sq_wmask into dmem_addr/dmem_wdata/dmem_wmask; go to STORE_WAIT. Stores have fixed priority.
  - else ld_req && !flush: ld_gnt=1 (combinational); latch ld_addr/ld_rmask/ld_tag; go to LOAD_WAIT.
  - else stay in IDLE.
- STORE_WAIT + dmem_resp: sq_deq=1 and store_done=1 in the same cycle; clear dmem_wmask; go to IDLE. flush has no effect on STORE_WAIT.
- LOAD_WAIT + dmem_resp:
  - ld_resp = !drop && !flush.
  - ld_rdata = dmem_rdata; ld_resp_tag = latched tag.
  - Clear dmem_rmask and drop; go to IDLE.
- flush in LOAD_WAIT without dmem_resp sets drop. The access still completes and is consumed silently.
- dmem_resp in IDLE is ignored.
- dmem_rmask and dmem_wmask are never both nonzero.
- ld_gnt, sq_deq, store_done and ld_resp are 0 whenever their condition is false.
- Load/store address ordering is resolved upstream. This block does not compare addresses.

## Timing
- dmem_* outputs are registered. The request appears the cycle after the IDLE decision and holds stable until the dmem_resp cycle inclusive.
- Minimum occupancy is 2 cycles per access (decide, then a resp cycle ≥1 later). The back-to-back decision is made on the first IDLE cycle after resp.
- sq_deq, store_done, ld_resp, ld_rdata: combinational from dmem_resp, 0 cycles added.
- ld_gnt is asserted in the IDLE decision cycle. ld_req may drop the next cycle.
- Async rst mid-access:
  - Immediately returns to IDLE and clears all outputs, including dmem masks.
  - No sq_deq or store_done is issued for the aborted access.
  - A late dmem_resp after reset is ignored.

## Test plan
- Store commit: sq_valid=1, sq_rob_idx=3, rob_head_idx=3, addr 0x1000, wdata 0xDEADBEEF, wmask 0xF.
  - Expected: next cycle dmem_wmask=0xF, addr 0x1000.
  - With dmem_resp 2 cycles later: sq_deq=store_done=1 for exactly 1 cycle, then masks 0.
- Uncommitted store blocked: sq_rob_idx=4, rob_head_idx=3, ld_req addr 0x2000 tag 5.
  - Expected: ld_gnt=1, dmem_rmask nonzero, no write.
  - dmem_resp with rdata 0x12345678 → ld_resp=1, ld_rdata=0x12345678, tag 5.
- Priority: st_ok and ld_req in the same IDLE cycle.
  - Expected: store issued, ld_gnt=0.
  - After the store resp, the load is granted on the next IDLE cycle.
- Flush while the load is in flight:
  - Flush asserted in LOAD_WAIT 1 cycle before dmem_resp → ld_resp stays 0; the next load responds normally.
  - Flush in the same cycle as dmem_resp → ld_resp=0.
  - Flush in IDLE with ld_req → ld_gnt=0.
- Reset: rst pulsed mid STORE_WAIT.
  - Expected: all outputs 0 immediately, state IDLE.
  - A following stray dmem_resp produces no sq_deq or store_done.
- Flush during a store: flush in STORE_WAIT → write still completes, sq_deq=1.

Source files
------------

// File: rtl/dmem_port_sched_if.sv
// Bundle between the scheduler and its neighbours: store-queue head, ROB head,
// load unit and the single data-memory port.
//
// Handshake semantics used throughout this bundle:
//   - ld_req is a valid that stays high, with stable ld_addr/ld_rmask/ld_tag,
//     until ld_gnt is seen in the same cycle; ld_gnt is the ready for it.
//   - sq_valid presents the store-queue head; it is consumed only by the
//     one-cycle sq_deq pulse, which coincides with store_done.
//   - dmem_rmask/dmem_wmask nonzero is the memory request valid; the request
//     holds until, and including, the single dmem_resp cycle that completes it.
//   - ld_resp is a one-cycle valid with no back-pressure.
interface dmem_port_sched_if #(
  parameter int ROB_IDX_W = 5,
  parameter int TAG_W     = 4
);
  logic                 sq_valid;
  logic [31:0]          sq_addr;
  logic [31:0]          sq_wdata;
  logic [3:0]           sq_wmask;
  logic [ROB_IDX_W-1:0] sq_rob_idx;
  logic                 sq_deq;
  logic                 rob_head_valid;
  logic [ROB_IDX_W-1:0] rob_head_idx;
  logic                 store_done;
  logic                 ld_req;
  logic [31:0]          ld_addr;
  logic [3:0]           ld_rmask;
  logic [TAG_W-1:0]     ld_tag;
  logic                 ld_gnt;
  logic                 ld_resp;
  logic [31:0]          ld_rdata;
  logic [TAG_W-1:0]     ld_resp_tag;
  logic                 flush;
  logic [31:0]          dmem_addr;
  logic [3:0]           dmem_rmask;
  logic [3:0]           dmem_wmask;
  logic [31:0]          dmem_wdata;
  logic [31:0]          dmem_rdata;
  logic                 dmem_resp;

  // Scheduler side
  modport slave (
    input  sq_valid, sq_addr, sq_wdata, sq_wmask, sq_rob_idx,
    input  rob_head_valid, rob_head_idx,
    input  ld_req, ld_addr, ld_rmask, ld_tag,
    input  flush, dmem_rdata, dmem_resp,
    output sq_deq, store_done, ld_gnt, ld_resp, ld_rdata, ld_resp_tag,
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata
  );

  // Environment side (store queue, ROB, load unit, memory)
  modport master (
    output sq_valid, sq_addr, sq_wdata, sq_wmask, sq_rob_idx,
    output rob_head_valid, rob_head_idx,
    output ld_req, ld_addr, ld_rmask, ld_tag,
    output flush, dmem_rdata, dmem_resp,
    input  sq_deq, store_done, ld_gnt, ld_resp, ld_rdata, ld_resp_tag,
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata
  );
endinterface

// File: rtl/dmem_port_sched.sv
// Single-port data-memory scheduler. Drains committed stores from the
// store-queue head (fixed priority) and issues speculative loads, with one
// outstanding memory access at a time. Loads squashed by flush still occupy
// the port until their response arrives, which is then swallowed.
module dmem_port_sched #(
  parameter int ROB_IDX_W = 5,
  parameter int TAG_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  dmem_port_sched_if.slave    bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STORE_WAIT = 2'd1,
    LOAD_WAIT  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_drop;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [3:0]           r_wmask;
  logic [3:0]           r_rmask;
  logic [TAG_W-1:0]     r_tag;

  logic [ROB_IDX_W-1:0] w_sq_idx;
  logic [ROB_IDX_W-1:0] w_head_idx;
  logic                 w_st_ok;
  logic                 w_take_store;
  logic                 w_take_load;
  logic                 w_store_fin;
  logic                 w_load_fin;
  logic                 w_set_drop;

  assign w_sq_idx    = bus.sq_rob_idx;
  assign w_head_idx  = bus.rob_head_idx;
  // A store may be written only once it is the oldest instruction in the ROB.
  assign w_st_ok     = bus.sq_valid && bus.rob_head_valid && (w_sq_idx == w_head_idx);

  assign o_dbg_state = r_state;

  // Memory request outputs come straight from registers.
  assign bus.dmem_addr  = r_addr;
  assign bus.dmem_wdata = r_wdata;
  assign bus.dmem_wmask = r_wmask;
  assign bus.dmem_rmask = r_rmask;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode, arbitration and the combinational response pulses
  always_comb begin
    w_state_nxt     = r_state;
    w_take_store    = 1'b0;
    w_take_load     = 1'b0;
    w_store_fin     = 1'b0;
    w_load_fin      = 1'b0;
    w_set_drop      = 1'b0;
    bus.ld_gnt      = 1'b0;
    bus.sq_deq      = 1'b0;
    bus.store_done  = 1'b0;
    bus.ld_resp     = 1'b0;
    bus.ld_rdata    = 32'd0;
    bus.ld_resp_tag = '0;
    case (r_state)
      IDLE: begin
        if (w_st_ok) begin
          w_take_store = 1'b1;
          w_state_nxt  = STORE_WAIT;
        end else if (bus.ld_req && !bus.flush) begin
          // Grant is suppressed while reset is held so every output reads 0.
          bus.ld_gnt   = !rst;
          w_take_load  = 1'b1;
          w_state_nxt  = LOAD_WAIT;
        end
      end
      STORE_WAIT: begin
        // flush is deliberately ignored: a committed store must complete.
        if (bus.dmem_resp) begin
          bus.sq_deq     = 1'b1;
          bus.store_done = 1'b1;
          w_store_fin    = 1'b1;
          w_state_nxt    = IDLE;
        end
      end
      LOAD_WAIT: begin
        if (bus.dmem_resp) begin
          bus.ld_resp     = !r_drop && !bus.flush;
          bus.ld_rdata    = bus.dmem_rdata;
          bus.ld_resp_tag = r_tag;
          w_load_fin      = 1'b1;
          w_state_nxt     = IDLE;
        end else if (bus.flush) begin
          w_set_drop = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, mask clearing on completion, and the squash flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wmask <= 4'd0;
      r_rmask <= 4'd0;
      r_tag   <= '0;
      r_drop  <= 1'b0;
    end else begin
      if (w_take_store) begin
        r_addr  <= bus.sq_addr;
        r_wdata <= bus.sq_wdata;
        r_wmask <= bus.sq_wmask;
      end else if (w_take_load) begin
        r_addr  <= bus.ld_addr;
        r_rmask <= bus.ld_rmask;
        r_tag   <= bus.ld_tag;
      end
      if (w_store_fin) begin
        r_wmask <= 4'd0;
      end
      if (w_load_fin) begin
        r_rmask <= 4'd0;
        r_drop  <= 1'b0;
      end else if (w_set_drop) begin
        r_drop  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_sched.sv
// Bench for dmem_port_sched: reset checks, a table of single-access scenarios,
// hand-written multi-cycle sequences (priority hand-over, reset mid-store) and
// a randomized run against a queue-based model of the outstanding access.
module tb_dmem_port_sched;
  localparam int ROB_IDX_W = 5;
  localparam int TAG_W     = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  dmem_port_sched_if #(.ROB_IDX_W(ROB_IDX_W), .TAG_W(TAG_W)) dif ();

  dmem_port_sched #(.ROB_IDX_W(ROB_IDX_W), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (dif),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    dif.sq_valid       = 1'b0;
    dif.sq_addr        = 32'd0;
    dif.sq_wdata       = 32'd0;
    dif.sq_wmask       = 4'd0;
    dif.sq_rob_idx     = '0;
    dif.rob_head_valid = 1'b0;
    dif.rob_head_idx   = '0;
    dif.ld_req         = 1'b0;
    dif.ld_addr        = 32'd0;
    dif.ld_rmask       = 4'd0;
    dif.ld_tag         = '0;
    dif.flush          = 1'b0;
    dif.dmem_rdata     = 32'd0;
    dif.dmem_resp      = 1'b0;
  endtask

  task automatic check_all_zero(input string tn);
    check({tn, ".wmask"}, 32'(dif.dmem_wmask), 32'd0);
    check({tn, ".rmask"}, 32'(dif.dmem_rmask), 32'd0);
    check({tn, ".addr"}, dif.dmem_addr, 32'd0);
    check({tn, ".wdata"}, dif.dmem_wdata, 32'd0);
    check({tn, ".gnt"}, 32'(dif.ld_gnt), 32'd0);
    check({tn, ".deq"}, 32'(dif.sq_deq), 32'd0);
    check({tn, ".done"}, 32'(dif.store_done), 32'd0);
    check({tn, ".ld_resp"}, 32'(dif.ld_resp), 32'd0);
    check({tn, ".state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- vector table ----------------
  // flush_mode: 0 none, 1 one cycle before resp, 2 on resp cycle, 3 in IDLE decision
  typedef struct {
    logic        sq_valid;
    logic [4:0]  sq_rob;
    logic        rob_hv;
    logic [4:0]  rob_head;
    logic [31:0] sq_addr;
    logic [31:0] sq_wdata;
    logic [3:0]  sq_wmask;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [3:0]  ld_rmask;
    logic [3:0]  ld_tag;
    logic [31:0] rdata;
    int          delay;
    int          flush_mode;
    logic        exp_gnt;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wmask;
    logic [3:0]  exp_rmask;
    logic        exp_deq;
    logic        exp_ld_resp;
    logic [3:0]  exp_tag;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v, input int idx);
    string tn;
    logic  active;
    tn     = $sformatf("v%0d", idx);
    active = (v.exp_wmask != 4'd0) || (v.exp_rmask != 4'd0);
    dif.sq_valid       = v.sq_valid;
    dif.sq_rob_idx     = v.sq_rob;
    dif.rob_head_valid = v.rob_hv;
    dif.rob_head_idx   = v.rob_head;
    dif.sq_addr        = v.sq_addr;
    dif.sq_wdata       = v.sq_wdata;
    dif.sq_wmask       = v.sq_wmask;
    dif.ld_req         = v.ld_req;
    dif.ld_addr        = v.ld_addr;
    dif.ld_rmask       = v.ld_rmask;
    dif.ld_tag         = v.ld_tag;
    dif.flush          = (v.flush_mode == 3);
    dif.dmem_resp      = 1'b0;
    #1;
    check({tn, ".gnt"}, 32'(dif.ld_gnt), 32'(v.exp_gnt));
    tick();
    dif.ld_req = 1'b0;
    dif.flush  = 1'b0;
    check({tn, ".req_wmask"}, 32'(dif.dmem_wmask), 32'(v.exp_wmask));
    check({tn, ".req_rmask"}, 32'(dif.dmem_rmask), 32'(v.exp_rmask));
    if (!active) begin
      dif.sq_valid = 1'b0;
      return;
    end
    check({tn, ".req_addr"}, dif.dmem_addr, v.exp_addr);
    for (int i = 0; i < v.delay; i++) begin
      dif.flush = (v.flush_mode == 1) && (i == v.delay - 1);
      #1;
      check({tn, ".early_deq"}, 32'(dif.sq_deq), 32'd0);
      tick();
    end
    dif.dmem_resp  = 1'b1;
    dif.dmem_rdata = v.rdata;
    dif.flush      = (v.flush_mode == 2);
    #1;
    check({tn, ".deq"}, 32'(dif.sq_deq), 32'(v.exp_deq));
    check({tn, ".done"}, 32'(dif.store_done), 32'(v.exp_deq));
    check({tn, ".ld_resp"}, 32'(dif.ld_resp), 32'(v.exp_ld_resp));
    if (v.exp_ld_resp) begin
      check({tn, ".rdata"}, dif.ld_rdata, v.rdata);
      check({tn, ".tag"}, 32'(dif.ld_resp_tag), 32'(v.exp_tag));
    end
    check({tn, ".hold_wmask"}, 32'(dif.dmem_wmask), 32'(v.exp_wmask));
    tick();
    dif.dmem_resp = 1'b0;
    dif.flush     = 1'b0;
    dif.sq_valid  = 1'b0;
    #1;
    check({tn, ".post_wmask"}, 32'(dif.dmem_wmask), 32'd0);
    check({tn, ".post_rmask"}, 32'(dif.dmem_rmask), 32'd0);
    check({tn, ".post_deq"}, 32'(dif.sq_deq), 32'd0);
    check({tn, ".post_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- scoreboard for random phase ----------------
  typedef struct {
    logic        is_store;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [3:0]  tag;
    logic        drop;
  } acc_t;

  acc_t exp_q[$];

  task automatic random_phase(input int cycles);
    logic busy, st_ok, e_gnt, e_deq, e_resp;
    logic last_gnt, last_deq, last_flush;
    acc_t cur, nw;
    last_gnt = 1'b0; last_deq = 1'b0; last_flush = 1'b0;
    exp_q.delete();
    for (int c = 0; c < cycles; c++) begin
      if (!dif.ld_req || last_gnt || last_flush) begin
        dif.ld_req   = ($urandom_range(0, 2) != 0);
        dif.ld_addr  = $urandom & 32'hFFFF_FFFC;
        dif.ld_rmask = 4'($urandom_range(1, 15));
        dif.ld_tag   = 4'($urandom_range(0, 15));
      end
      if (!dif.sq_valid || last_deq) begin
        dif.sq_valid   = ($urandom_range(0, 1) != 0);
        dif.sq_addr    = $urandom & 32'hFFFF_FFFC;
        dif.sq_wdata   = $urandom;
        dif.sq_wmask   = 4'($urandom_range(1, 15));
        dif.sq_rob_idx = 5'($urandom_range(0, 31));
      end
      dif.rob_head_valid = ($urandom_range(0, 3) != 0);
      dif.rob_head_idx   = ($urandom_range(0, 1) != 0) ? dif.sq_rob_idx : 5'($urandom_range(0, 31));
      dif.dmem_resp      = ($urandom_range(0, 2) == 0);
      dif.dmem_rdata     = $urandom;
      dif.flush          = ($urandom_range(0, 5) == 0);
      #1;
      busy   = (exp_q.size() != 0);
      st_ok  = dif.sq_valid && dif.rob_head_valid && (dif.sq_rob_idx == dif.rob_head_idx);
      e_gnt  = !busy && !st_ok && dif.ld_req && !dif.flush;
      e_deq  = 1'b0;
      e_resp = 1'b0;
      if (busy) cur = exp_q[0];
      if (busy && dif.dmem_resp) begin
        if (cur.is_store) e_deq = 1'b1;
        else e_resp = !cur.drop && !dif.flush;
      end
      check("rnd.gnt", 32'(dif.ld_gnt), 32'(e_gnt));
      check("rnd.deq", 32'(dif.sq_deq), 32'(e_deq));
      check("rnd.done", 32'(dif.store_done), 32'(e_deq));
      check("rnd.ld_resp", 32'(dif.ld_resp), 32'(e_resp));
      if (e_resp) begin
        check("rnd.rdata", dif.ld_rdata, dif.dmem_rdata);
        check("rnd.tag", 32'(dif.ld_resp_tag), 32'(cur.tag));
      end
      check("rnd.wmask", 32'(dif.dmem_wmask), (busy && cur.is_store) ? 32'(cur.mask) : 32'd0);
      check("rnd.rmask", 32'(dif.dmem_rmask), (busy && !cur.is_store) ? 32'(cur.mask) : 32'd0);
      if (busy) check("rnd.addr", dif.dmem_addr, cur.addr);
      if (busy && cur.is_store) check("rnd.wdata", dif.dmem_wdata, cur.data);
      // advance the model across the coming clock edge
      if (busy) begin
        if (dif.dmem_resp) void'(exp_q.pop_front());
        else if (!cur.is_store && dif.flush) begin
          cur.drop = 1'b1;
          exp_q[0] = cur;
        end
      end else if (st_ok) begin
        nw = '{1'b1, dif.sq_addr, dif.sq_wdata, dif.sq_wmask, 4'd0, 1'b0};
        exp_q.push_back(nw);
      end else if (e_gnt) begin
        nw = '{1'b0, dif.ld_addr, 32'd0, dif.ld_rmask, dif.ld_tag, 1'b0};
        exp_q.push_back(nw);
      end
      last_gnt   = e_gnt;
      last_deq   = e_deq;
      last_flush = dif.flush;
      tick();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    #2;
    check_all_zero("reset_held");
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_all_zero("reset_rel");
    tick();

    //        sqv rob   hv head  sq_addr        wdata          wm    ldr ld_addr        rm    tag   rdata          dly fm gnt exp_addr       ewm   erm   deq rsp etag
    vecs[0] = '{1, 5'd3, 1, 5'd3, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         4'h0, 4'h0, 32'h0,         2, 0, 0, 32'h0000_1000, 4'hF, 4'h0, 1, 0, 4'h0};
    vecs[1] = '{1, 5'd4, 1, 5'd3, 32'h0000_1100, 32'h1111_2222, 4'h3, 1, 32'h0000_2000, 4'hF, 4'h5, 32'h1234_5678, 1, 0, 1, 32'h0000_2000, 4'h0, 4'hF, 0, 1, 4'h5};
    vecs[2] = '{1, 5'd7, 1, 5'd7, 32'h0000_3000, 32'hCAFE_F00D, 4'h3, 1, 32'h0000_4000, 4'hF, 4'h9, 32'h0,         1, 0, 0, 32'h0000_3000, 4'h3, 4'h0, 1, 0, 4'h0};
    vecs[3] = '{0, 5'd0, 0, 5'd0, 32'h0,         32'h0,         4'h0, 1, 32'h0000_5000, 4'h5, 4'h2, 32'hBAD0_BAD0, 2, 1, 1, 32'h0000_5000, 4'h0, 4'h5, 0, 0, 4'h2};
    vecs[4] = '{1, 5'd9, 0, 5'd9, 32'h0000_7700, 32'h0,         4'h1, 1, 32'h0000_5004, 4'h8, 4'hF, 32'hA5A5_5A5A, 1, 0, 1, 32'h0000_5004, 4'h0, 4'h8, 0, 1, 4'hF};
    vecs[5] = '{0, 5'd0, 1, 5'd2, 32'h0,         32'h0,         4'h0, 1, 32'h0000_6000, 4'hC, 4'h3, 32'h7777_7777, 0, 2, 1, 32'h0000_6000, 4'h0, 4'hC, 0, 0, 4'h3};
    vecs[6] = '{0, 5'd0, 1, 5'd2, 32'h0,         32'h0,         4'h0, 1, 32'h0000_6100, 4'hF, 4'h6, 32'h0,         1, 3, 0, 32'h0,         4'h0, 4'h0, 0, 0, 4'h0};
    vecs[7] = '{1, 5'd1, 1, 5'd1, 32'h0000_8000, 32'h0BAD_CAFE, 4'h6, 0, 32'h0,         4'h0, 4'h0, 32'h0,         1, 1, 0, 32'h0000_8000, 4'h6, 4'h0, 1, 0, 4'h0};
    vecs[8] = '{1, 5'd31, 1, 5'd31, 32'h0000_9000, 32'h0000_00FF, 4'h1, 0, 32'h0,       4'h0, 4'h0, 32'h0,         0, 2, 0, 32'h0000_9000, 4'h1, 4'h0, 1, 0, 4'h0};
    vecs[9] = '{0, 5'd0, 1, 5'd0, 32'h0,         32'h0,         4'h0, 1, 32'h0000_A000, 4'h2, 4'hA, 32'h0F0F_F0F0, 3, 0, 1, 32'h0000_A000, 4'h0, 4'h2, 0, 1, 4'hA};

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Priority hand-over: load waiting behind a store is granted on the first IDLE cycle after resp
    dif.sq_valid = 1'b1; dif.sq_rob_idx = 5'd12; dif.rob_head_valid = 1'b1; dif.rob_head_idx = 5'd12;
    dif.sq_addr = 32'h0000_B000; dif.sq_wdata = 32'h1357_9BDF; dif.sq_wmask = 4'hF;
    dif.ld_req = 1'b1; dif.ld_addr = 32'h0000_C000; dif.ld_rmask = 4'hF; dif.ld_tag = 4'd7;
    #1;
    check("prio.gnt0", 32'(dif.ld_gnt), 32'd0);
    tick();
    check("prio.wmask", 32'(dif.dmem_wmask), 32'hF);
    check("prio.rmask", 32'(dif.dmem_rmask), 32'd0);
    dif.dmem_resp = 1'b1;
    #1;
    check("prio.deq", 32'(dif.sq_deq), 32'd1);
    check("prio.gnt_in_wait", 32'(dif.ld_gnt), 32'd0);
    tick();
    dif.dmem_resp = 1'b0; dif.sq_valid = 1'b0;
    #1;
    check("prio.gnt1", 32'(dif.ld_gnt), 32'd1);
    tick();
    dif.ld_req = 1'b0;
    check("prio.ld_rmask", 32'(dif.dmem_rmask), 32'hF);
    check("prio.ld_addr", dif.dmem_addr, 32'h0000_C000);
    dif.dmem_resp = 1'b1; dif.dmem_rdata = 32'h2468_ACE0;
    #1;
    check("prio.ld_resp", 32'(dif.ld_resp), 32'd1);
    check("prio.ld_tag", 32'(dif.ld_resp_tag), 32'd7);
    tick();
    dif.dmem_resp = 1'b0;

    // Reset mid STORE_WAIT, then a stray response
    dif.sq_valid = 1'b1; dif.sq_rob_idx = 5'd20; dif.rob_head_valid = 1'b1; dif.rob_head_idx = 5'd20;
    dif.sq_addr = 32'h0000_D000; dif.sq_wdata = 32'hFFFF_0000; dif.sq_wmask = 4'hC;
    tick();
    check("rstmid.wmask_before", 32'(dif.dmem_wmask), 32'hC);
    check("rstmid.state_before", 32'(dbg_state), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rstmid");
    dif.sq_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    dif.dmem_resp = 1'b1;
    #1;
    check("rstmid.stray_deq", 32'(dif.sq_deq), 32'd0);
    check("rstmid.stray_done", 32'(dif.store_done), 32'd0);
    check("rstmid.stray_ld_resp", 32'(dif.ld_resp), 32'd0);
    tick();
    dif.dmem_resp = 1'b0;
    #1;
    check("rstmid.after_wmask", 32'(dif.dmem_wmask), 32'd0);
    check("rstmid.after_state", 32'(dbg_state), 32'd0);
    idle_inputs();
    tick();

    random_phase(1500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
